// File: rtl/his_readout_fsm_if.sv
// ----------------------------------------------------------------------------
// his_readout_fsm_if
//   Valid/ready stream carrying histogram bin counts from the readout FSM to
//   the downstream data-formatting logic.
//
//   out_valid  master->slave  beat valid
//   out_ready  slave->master  beat accepted when high together with out_valid
//   out_data   master->slave  bin count
//   out_pixel  master->slave  pixel index
//   out_bin    master->slave  bin index within the pixel (upper bits 0)
//   out_last   master->slave  last bin of the current pixel
//   out_eof    master->slave  last bin of the last pixel
// ----------------------------------------------------------------------------
interface his_readout_fsm_if #(
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 12
);
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_data;
    logic [7:0]        out_pixel;
    logic [ADDR_W-1:0] out_bin;
    logic              out_last;
    logic              out_eof;

    modport master (
        output out_valid, out_data, out_pixel, out_bin, out_last, out_eof,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_pixel, out_bin, out_last, out_eof,
        output out_ready
    );
endinterface

// File: rtl/his_readout_fsm.sv
// ----------------------------------------------------------------------------
// his_readout_fsm
//   Reader side of the histogram RAM. On a completed acquisition it walks the
//   frozen bank pixel by pixel, bin by bin, streams every bin count out on a
//   valid/ready stream and clears each bin once it has been accepted, leaving
//   the bank zeroed for the next bank swap.
//
//   Optional feature macro: HIS_PEAK_DETECT_EN adds a per-pixel peak reporter
//   (peak_valid / peak_bin / peak_count).
//
// Ports
//   clk        in   system clock, rising edge
//   res        in   asynchronous reset, active-low
//   start      in   1-cycle pulse: acquisition complete
//   his_num    in   bank just completed, latched on an accepted start
//   rd_en      out  RAM read strobe (data returns one cycle later)
//   rd_bank    out  bank select for read and clear
//   rd_addr    out  read address = pixel*BIN_NUM_PER_HIS + bin
//   rd_data    in   RAM read data
//   clr_en     out  RAM write strobe, writes 0 to clr_addr
//   clr_addr   out  address being cleared
//   out_if     ---  outgoing bin-count stream (master side)
//   busy       out  high from accepted start until the DONE cycle
//   done       out  1-cycle pulse after the final handshake
//   overrun    out  sticky: start seen while a readout was in progress
//   peak_*     out  (HIS_PEAK_DETECT_EN only) per-pixel maximum, pulsed with
//                   the out_last handshake; ties keep the lowest bin
// ----------------------------------------------------------------------------
module his_readout_fsm #(
    parameter int BIN_NUM_PER_HIS = 16,
    parameter int PIXEL_NUM       = 200,
    parameter int CNT_W           = 8,
    parameter int ADDR_W          = 12
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic              his_num,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [CNT_W-1:0]  rd_data,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr,
    his_readout_fsm_if.master out_if,
    output logic              busy,
    output logic              done,
`ifdef HIS_PEAK_DETECT_EN
    output logic              peak_valid,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [CNT_W-1:0]  peak_count,
`endif
    output logic              overrun
);
    localparam int BIN_W = $clog2(BIN_NUM_PER_HIS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_SEND,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              bank_q;
    logic [7:0]        pixel_q;
    logic [BIN_W-1:0]  bin_q;
    logic [CNT_W-1:0]  data_q;
    logic              overrun_q;
    logic              out_valid;
    logic              last_bin;
    logic              last_pixel;
    logic              handshake;
    logic [ADDR_W-1:0] cur_addr;

    assign last_bin   = (bin_q == BIN_W'(BIN_NUM_PER_HIS - 1));
    assign last_pixel = (pixel_q == 8'(PIXEL_NUM - 1));
    assign handshake  = out_valid && out_if.out_ready;
    assign cur_addr   = ADDR_W'(pixel_q) * ADDR_W'(BIN_NUM_PER_HIS) + ADDR_W'(bin_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge res) begin
        if (!res) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        rd_en     = 1'b0;
        clr_en    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_RD;
            S_RD: begin
                rd_en   = 1'b1;
                busy    = 1'b1;
                state_d = S_CAP;
            end
            S_CAP: begin
                busy    = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // The bin is cleared in the very cycle it is accepted, so a
                // stalled beat never loses its count in RAM.
                if (out_if.out_ready) begin
                    clr_en  = 1'b1;
                    state_d = (last_bin && last_pixel) ? S_DONE : S_RD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counters and payload only move on an accepted start, in CAP, or on a
    // handshake, which keeps the stream payload stable while stalled.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            bank_q    <= 1'b0;
            pixel_q   <= '0;
            bin_q     <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        bank_q    <= his_num;
                        pixel_q   <= '0;
                        bin_q     <= '0;
                        overrun_q <= 1'b0;
                    end
                end
                S_CAP: data_q <= rd_data;
                S_SEND: begin
                    if (out_if.out_ready && !(last_bin && last_pixel)) begin
                        if (last_bin) begin
                            bin_q   <= '0;
                            pixel_q <= pixel_q + 8'd1;
                        end else begin
                            bin_q <= bin_q + BIN_W'(1);
                        end
                    end
                end
                default: ;
            endcase
            if (start && state_q != S_IDLE) overrun_q <= 1'b1;
        end
    end

    assign rd_bank  = bank_q;
    assign rd_addr  = cur_addr;
    assign clr_addr = cur_addr;
    assign overrun  = overrun_q;

    assign out_if.out_valid = out_valid;
    assign out_if.out_data  = data_q;
    assign out_if.out_pixel = pixel_q;
    assign out_if.out_bin   = ADDR_W'(bin_q);
    // Sideband flags are qualified with valid so they read 0 between beats.
    assign out_if.out_last  = out_valid && last_bin;
    assign out_if.out_eof   = out_valid && last_bin && last_pixel;

`ifdef HIS_PEAK_DETECT_EN
    logic [BIN_W-1:0] trk_bin_q;
    logic [CNT_W-1:0] trk_cnt_q;
    logic             take_cur;
    logic [BIN_W-1:0] pk_bin;
    logic [CNT_W-1:0] pk_cnt;

    // Bin 0 always seeds the tracker; later bins replace it only when
    // strictly larger, so ties keep the lowest bin.
    assign take_cur = (bin_q == '0) || (data_q > trk_cnt_q);
    assign pk_bin   = take_cur ? bin_q  : trk_bin_q;
    assign pk_cnt   = take_cur ? data_q : trk_cnt_q;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            trk_bin_q <= '0;
            trk_cnt_q <= '0;
        end else if (handshake) begin
            trk_bin_q <= last_bin ? '0 : pk_bin;
            trk_cnt_q <= last_bin ? '0 : pk_cnt;
        end
    end

    assign peak_valid = handshake && last_bin;
    assign peak_bin   = peak_valid ? ADDR_W'(pk_bin) : '0;
    assign peak_count = peak_valid ? pk_cnt : '0;
`endif
endmodule
